// File: rtl/eth_rx_lb_pkg.sv
// Shared definitions for the RX-tile load balancer: FSM state encoding,
// destination-selection mode encodings and default header field offsets.
package eth_rx_lb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } lb_state_e;

  // Destination-selection modes
  localparam int HASH_RR   = 0;
  localparam int HASH_FLOW = 1;

  // Default header flit field positions
  localparam int DEF_DST_X_LSB = 0;
  localparam int DEF_DST_Y_LSB = 8;
  localparam int DEF_LEN_LSB   = 16;
  localparam int DEF_FLOW_LSB  = 64;
  localparam int DEF_FLOW_W    = 32;

endpackage

// File: rtl/eth_rx_lb_pick.sv
// Next-enabled-index search: returns the first index at or after start whose
// enable bit is set, wrapping modulo NUM_DST. found=0 when the mask is empty.
module eth_rx_lb_pick
  import eth_rx_lb_pkg::*;
#(
  parameter int NUM_DST   = 4,
  parameter int DST_IDX_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
  input  logic [DST_IDX_W-1:0] start,
  input  logic [NUM_DST-1:0]   en,
  output logic [DST_IDX_W-1:0] idx,
  output logic                 found
);

  logic [DST_IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest enabled index wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_DST - 1; k >= 0; k--) begin
      cand = DST_IDX_W'((int'(start) + k) % NUM_DST);
      if (en[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/eth_rx_lb_steer.sv
// RX-tile load balancer: steers whole NoC messages (header + body flits) to
// one of NUM_DST destinations, rewriting dst X/Y in the header flit.
// Selection is round-robin over cfg_dst_en or a flow-hash XOR fold.
// Optional per-destination frame counters: define ETH_RX_LB_STATS_EN.
//
// Handshake: a flit moves on any edge where valid & ready are both high.
// Valid never depends on ready; once lb_dst_val is high, lb_dst_val and
// lb_dst_data hold until dst_lb_rdy is seen high.
module eth_rx_lb_steer
  import eth_rx_lb_pkg::*;
#(
  parameter int NOC_DATA_W = 512,
  parameter int NUM_DST    = 4,
  parameter int DST_IDX_W  = (NUM_DST > 1) ? $clog2(NUM_DST) : 1,
  parameter int XY_W       = 8,
  parameter int LEN_W      = 8,
  parameter int DST_X_LSB  = DEF_DST_X_LSB,
  parameter int DST_Y_LSB  = DEF_DST_Y_LSB,
  parameter int LEN_LSB    = DEF_LEN_LSB,
  parameter int FLOW_LSB   = DEF_FLOW_LSB,
  parameter int FLOW_W     = DEF_FLOW_W,
  parameter int HASH_MODE  = HASH_RR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    src_lb_val,
  input  logic [NOC_DATA_W-1:0]   src_lb_data,
  output logic                    lb_src_rdy,
  output logic                    lb_dst_val,
  output logic [NOC_DATA_W-1:0]   lb_dst_data,
  input  logic                    dst_lb_rdy,
  input  logic [NUM_DST*XY_W-1:0] cfg_dst_x,
  input  logic [NUM_DST*XY_W-1:0] cfg_dst_y,
  input  logic [NUM_DST-1:0]      cfg_dst_en
`ifdef ETH_RX_LB_STATS_EN
  ,
  output logic [NUM_DST*32-1:0]   lb_frame_cnt
`endif
);

  lb_state_e             state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DST_IDX_W-1:0]  rr_ptr_q, rr_next;
  logic [DST_IDX_W-1:0]  start_idx, pick_idx;
  logic                  pick_found;
  logic                  out_free, accept, hdr_accept;
  logic [LEN_W-1:0]      hdr_len;
  logic [NOC_DATA_W-1:0] hdr_data;

  // XOR-fold the flow field down to a destination index
  function automatic logic [DST_IDX_W-1:0] flow_fold(input logic [FLOW_W-1:0] flow);
    logic [DST_IDX_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FLOW_W; i += DST_IDX_W) acc ^= DST_IDX_W'(flow >> i);
    return acc;
  endfunction

  assign hdr_len   = src_lb_data[LEN_LSB +: LEN_W];
  assign start_idx = (HASH_MODE == HASH_FLOW) ? flow_fold(src_lb_data[FLOW_LSB +: FLOW_W])
                                              : rr_ptr_q;
  assign rr_next   = DST_IDX_W'((int'(pick_idx) + 1) % NUM_DST);

  eth_rx_lb_pick #(
    .NUM_DST  (NUM_DST),
    .DST_IDX_W(DST_IDX_W)
  ) u_pick (
    .start(start_idx),
    .en   (cfg_dst_en),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // Accept only when the output register is empty or draining this cycle;
  // a header additionally needs at least one enabled destination.
  assign out_free   = !lb_dst_val || dst_lb_rdy;
  assign lb_src_rdy = out_free && ((state_q == BODY) || pick_found);
  assign accept     = src_lb_val && lb_src_rdy;
  assign hdr_accept = accept && (state_q == IDLE);

  // Header rewrite: only dst X/Y change, every other bit passes through
  always_comb begin
    hdr_data = src_lb_data;
    hdr_data[DST_X_LSB +: XY_W] = cfg_dst_x[int'(pick_idx)*XY_W +: XY_W];
    hdr_data[DST_Y_LSB +: XY_W] = cfg_dst_y[int'(pick_idx)*XY_W +: XY_W];
  end

  // FSM next state: header-only messages stay in IDLE, others count body flits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && (hdr_len != '0)) begin
          state_d = BODY;
          cnt_d   = hdr_len;
        end
      end
      BODY: begin
        if (accept) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, body counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hdr_accept && (HASH_MODE == HASH_RR)) rr_ptr_q <= rr_next;
    end
  end

  // Single output register; reloads when draining and accepting together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_dst_val  <= 1'b0;
      lb_dst_data <= '0;
    end else if (accept) begin
      lb_dst_val  <= 1'b1;
      lb_dst_data <= (state_q == IDLE) ? hdr_data : src_lb_data;
    end else if (dst_lb_rdy) begin
      lb_dst_val  <= 1'b0;
    end
  end

`ifdef ETH_RX_LB_STATS_EN
  logic [DST_IDX_W-1:0] cur_idx_q, out_idx_q;
  logic                 out_last_q;

  // Track destination and last-flit flag alongside the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx_q  <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        cur_idx_q  <= pick_idx;
        out_idx_q  <= pick_idx;
        out_last_q <= (hdr_len == '0);
      end else begin
        out_idx_q  <= cur_idx_q;
        out_last_q <= (cnt_q == LEN_W'(1));
      end
    end
  end

  // Count a frame when its last flit leaves the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_frame_cnt <= '0;
    end else if (lb_dst_val && dst_lb_rdy && out_last_q) begin
      for (int i = 0; i < NUM_DST; i++) begin
        if (out_idx_q == DST_IDX_W'(i))
          lb_frame_cnt[i*32 +: 32] <= lb_frame_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_lb_steer.sv
// Bench for eth_rx_lb_steer: a round-robin and a flow-hash instance share the
// same stimulus; a message-level model predicts each output flit.
module tb_eth_rx_lb_steer;

  localparam int W  = 512;
  localparam int ND = 4;
  localparam int XW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              src_lb_val;
  logic [W-1:0]      src_lb_data;
  logic              dst_lb_rdy;
  logic [ND*XW-1:0]  cfg_dst_x, cfg_dst_y;
  logic [ND-1:0]     cfg_dst_en;
  logic              rdy_rr, val_rr, rdy_hs, val_hs;
  logic [W-1:0]      data_rr, data_hs;
`ifdef ETH_RX_LB_STATS_EN
  logic [ND*32-1:0]  fc_rr, fc_hs;
`endif

  eth_rx_lb_steer #(.HASH_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .src_lb_val(src_lb_val), .src_lb_data(src_lb_data),
    .lb_src_rdy(rdy_rr), .lb_dst_val(val_rr), .lb_dst_data(data_rr),
    .dst_lb_rdy(dst_lb_rdy), .cfg_dst_x(cfg_dst_x), .cfg_dst_y(cfg_dst_y),
    .cfg_dst_en(cfg_dst_en)
`ifdef ETH_RX_LB_STATS_EN
    , .lb_frame_cnt(fc_rr)
`endif
  );

  eth_rx_lb_steer #(.HASH_MODE(1)) u_hs (
    .clk(clk), .rst_n(rst_n), .src_lb_val(src_lb_val), .src_lb_data(src_lb_data),
    .lb_src_rdy(rdy_hs), .lb_dst_val(val_hs), .lb_dst_data(data_hs),
    .dst_lb_rdy(dst_lb_rdy), .cfg_dst_x(cfg_dst_x), .cfg_dst_y(cfg_dst_y),
    .cfg_dst_en(cfg_dst_en)
`ifdef ETH_RX_LB_STATS_EN
    , .lb_frame_cnt(fc_hs)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic last;
    int   idx;
    logic hdr;
  } meta_t;

  logic [W-1:0] exp_rr[$], exp_hs[$];
  meta_t        meta_rr[$], meta_hs[$];
  logic [W-1:0] src_q[$];
  int           m_rem, m_rr_ptr, m_cur_rr, m_cur_hs;
  logic         m_full;
  int           m_cnt_rr[ND], m_cnt_hs[ND];
  int           last_x_rr, last_x_hs;
  logic         acc_f;
  int           rdy_mode;
  logic         gaps, rand_cfg;
  logic         stall_p, exp_rdy;
  logic [W-1:0] stall_d_rr, stall_d_hs, fl;
  int           hl, ir, ih, cyc;
  meta_t        mt;

  // First enabled destination at or after start, or -1 if none
  function automatic int m_pick(input int start, input logic [ND-1:0] en);
    for (int k = 0; k < ND; k++)
      if (en[(start + k) % ND]) return (start + k) % ND;
    return -1;
  endfunction

  // XOR of all 2-bit chunks of the flow field
  function automatic int m_fold(input logic [31:0] f);
    int r;
    r = 0;
    for (int i = 0; i < 32; i += 2) r = r ^ int'((f >> i) & 32'd3);
    return r;
  endfunction

  // Destination i is configured at X=i, Y=0x40+i
  function automatic logic [W-1:0] rewrite(input logic [W-1:0] f, input int idx);
    f[0 +: 8] = 8'(idx);
    f[8 +: 8] = 8'(8'h40 + idx);
    return f;
  endfunction

  function automatic logic [W-1:0] rand_flit();
    logic [W-1:0] f;
    for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // ---------------- scoreboard / monitor (negedge) ----------------
  initial begin
    stall_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_rem = 0; m_rr_ptr = 0; m_full = 1'b0; acc_f = 1'b0; stall_p = 1'b0;
        m_cur_rr = 0; m_cur_hs = 0;
        exp_rr.delete(); exp_hs.delete(); meta_rr.delete(); meta_hs.delete();
        for (int i = 0; i < ND; i++) begin m_cnt_rr[i] = 0; m_cnt_hs[i] = 0; end
        continue;
      end
      exp_rdy = (!m_full || dst_lb_rdy) && (m_rem > 0 || cfg_dst_en != '0);
      check("src_rdy_rr", rdy_rr, exp_rdy);
      check("src_rdy_hs", rdy_hs, exp_rdy);
      check("dst_val_rr", val_rr, m_full);
      check("dst_val_hs", val_hs, m_full);
      if (stall_p) begin
        check("hold_data_rr", data_rr, stall_d_rr);
        check("hold_data_hs", data_hs, stall_d_hs);
      end
      stall_p    = val_rr && !dst_lb_rdy;
      stall_d_rr = data_rr;
      stall_d_hs = data_hs;
      // output side
      if (val_rr && dst_lb_rdy) begin
        if (exp_rr.size() == 0) check("unexpected_flit_rr", 1, 0);
        else begin
          check("flit_rr", data_rr, exp_rr.pop_front());
          mt = meta_rr.pop_front();
          if (mt.hdr) last_x_rr = int'(data_rr[7:0]);
          if (mt.last) m_cnt_rr[mt.idx]++;
        end
      end
      if (val_hs && dst_lb_rdy) begin
        if (exp_hs.size() == 0) check("unexpected_flit_hs", 1, 0);
        else begin
          check("flit_hs", data_hs, exp_hs.pop_front());
          mt = meta_hs.pop_front();
          if (mt.hdr) last_x_hs = int'(data_hs[7:0]);
          if (mt.last) m_cnt_hs[mt.idx]++;
        end
      end
      // input side
      if (src_lb_val && rdy_rr) begin
        acc_f = 1'b1;
        fl = src_lb_data;
        if (m_rem == 0) begin
          hl = int'(fl[16 +: 8]);
          ir = m_pick(m_rr_ptr, cfg_dst_en);
          ih = m_pick(m_fold(fl[64 +: 32]), cfg_dst_en);
          if (ir < 0) begin
            check("accept_while_disabled", 1, 0);
            ir = 0; ih = 0;
          end
          m_rr_ptr = (ir + 1) % ND;
          m_cur_rr = ir; m_cur_hs = ih;
          exp_rr.push_back(rewrite(fl, ir));
          exp_hs.push_back(rewrite(fl, ih));
          meta_rr.push_back('{last: (hl == 0), idx: ir, hdr: 1'b1});
          meta_hs.push_back('{last: (hl == 0), idx: ih, hdr: 1'b1});
          m_rem = hl;
        end else begin
          exp_rr.push_back(fl);
          exp_hs.push_back(fl);
          meta_rr.push_back('{last: (m_rem == 1), idx: m_cur_rr, hdr: 1'b0});
          meta_hs.push_back('{last: (m_rem == 1), idx: m_cur_hs, hdr: 1'b0});
          m_rem--;
        end
        m_full = 1'b1;
      end else if (dst_lb_rdy) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- driver (posedge + 1) ----------------
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (acc_f) begin
        void'(src_q.pop_front());
        acc_f = 1'b0;
        src_lb_val = 1'b0;
      end
      if (!src_lb_val) begin
        if (src_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          src_lb_val  = 1'b1;
          src_lb_data = src_q[0];
        end
      end
      case (rdy_mode)
        0:       dst_lb_rdy = 1'b1;
        1:       dst_lb_rdy = 1'($urandom_range(0, 1));
        default: dst_lb_rdy = (cyc % 3 == 0);
      endcase
      if (rand_cfg && $urandom_range(0, 7) == 0) cfg_dst_en = 4'($urandom_range(0, 15));
    end
  end

  task automatic push_msg(input int len, input logic [31:0] flow);
    logic [W-1:0] f;
    f = rand_flit();
    f[16 +: 8] = 8'(len);
    f[64 +: 32] = flow;
    src_q.push_back(f);
    for (int i = 0; i < len; i++) src_q.push_back(rand_flit());
  endtask

  task automatic wait_drain(input int budget, input string name, output int n);
    n = 0;
    while ((src_q.size() != 0 || exp_rr.size() != 0 || exp_hs.size() != 0 || src_lb_val)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, (n >= budget), 0);
    @(negedge clk);
  endtask

  task automatic check_stats(input string name);
`ifdef ETH_RX_LB_STATS_EN
    for (int i = 0; i < ND; i++) begin
      check({name, "_cnt_rr"}, fc_rr[i*32 +: 32], m_cnt_rr[i]);
      check({name, "_cnt_hs"}, fc_hs[i*32 +: 32], m_cnt_hs[i]);
    end
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  en;
    logic [31:0] flow;
    int          len;
    int          exp_rr;
    int          exp_hs;
  } vec_t;

  vec_t tbl[13];
  int   nw;

  initial begin
    tbl[0]  = '{4'b1111, 32'h0000_0000, 2, 0, 0};
    tbl[1]  = '{4'b1111, 32'h0000_0001, 2, 1, 1};
    tbl[2]  = '{4'b1111, 32'h0001_0000, 2, 2, 1};
    tbl[3]  = '{4'b1111, 32'h0000_0003, 2, 3, 3};
    tbl[4]  = '{4'b1010, 32'h0000_0002, 1, 1, 3};
    tbl[5]  = '{4'b1010, 32'h0000_0001, 1, 3, 1};
    tbl[6]  = '{4'b1010, 32'h0000_000C, 1, 1, 3};
    tbl[7]  = '{4'b1010, 32'h0000_0000, 0, 3, 1};
    tbl[8]  = '{4'b1101, 32'h0000_0001, 0, 0, 2};
    tbl[9]  = '{4'b1101, 32'h0001_0000, 0, 2, 2};
    tbl[10] = '{4'b1101, 32'h8000_0000, 3, 3, 2};
    tbl[11] = '{4'b0001, 32'hFFFF_FFFF, 0, 0, 0};
    tbl[12] = '{4'b1000, 32'h0000_0005, 2, 3, 3};

    for (int i = 0; i < ND; i++) begin
      cfg_dst_x[i*8 +: 8] = 8'(i);
      cfg_dst_y[i*8 +: 8] = 8'(8'h40 + i);
    end
    cfg_dst_en = 4'b1111;
    src_lb_val = 1'b0;
    src_lb_data = '0;
    dst_lb_rdy = 1'b1;
    rdy_mode = 0; gaps = 1'b0; rand_cfg = 1'b0;
    last_x_rr = -1; last_x_hs = -1;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_val_rr", val_rr, 0);
    check("reset_val_hs", val_hs, 0);
    check("reset_data_rr", data_rr, '0);
    check("reset_data_hs", data_hs, '0);
    check_stats("reset");
    rst_n = 1'b1;

    // table: round-robin order, enable masks, hash fold and redirect
    for (int i = 0; i < 13; i++) begin
      cfg_dst_en = tbl[i].en;
      push_msg(tbl[i].len, tbl[i].flow);
      wait_drain(200, "table", nw);
      check($sformatf("table%0d_dst_rr", i), last_x_rr, tbl[i].exp_rr);
      check($sformatf("table%0d_dst_hs", i), last_x_hs, tbl[i].exp_hs);
    end
    check_stats("table");

    // backpressure: output ready one cycle in three during a len=5 message
    cfg_dst_en = 4'b1111;
    rdy_mode = 2;
    push_msg(5, 32'h0000_0002);
    wait_drain(300, "bp", nw);
    rdy_mode = 0;

    // empty enable mask holds a pending header
    cfg_dst_en = 4'b0000;
    push_msg(0, 32'h0000_0003);
    repeat (20) begin
      @(negedge clk);
      check("en0_rdy_rr", rdy_rr, 0);
      check("en0_rdy_hs", rdy_hs, 0);
    end
    @(posedge clk);
    #2;
    cfg_dst_en = 4'b0001;
    @(negedge clk);
    check("en1_rdy_rr", rdy_rr, 1);
    check("en1_val", src_lb_val, 1);
    wait_drain(50, "en1", nw);
    check("en1_dst_rr", last_x_rr, 0);
    check("en1_dst_hs", last_x_hs, 0);

    // back-to-back header-only messages at full rate
    cfg_dst_en = 4'b1111;
    for (int i = 0; i < 4; i++) push_msg(0, 32'(i));
    wait_drain(50, "len0", nw);
    check("len0_cycles_le7", (nw <= 7), 1);
    check("len0_last_hs", last_x_hs, 3);
    check_stats("len0");

    // reset asserted in the middle of a len=4 body
    push_msg(4, 32'h0000_0001);
    nw = 0;
    while (m_rem != 3 && nw < 50) begin @(negedge clk); nw++; end
    check("midbody_reach_timeout", (nw >= 50), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    src_q.delete();
    src_lb_val = 1'b0;
    #1;
    check("midrst_val_rr", val_rr, 0);
    check("midrst_val_hs", val_hs, 0);
    repeat (2) @(posedge clk);
    #3;
    check_stats("midrst");
    rst_n = 1'b1;
    push_msg(0, 32'h0000_0002);
    wait_drain(50, "postrst", nw);
    check("postrst_dst_rr", last_x_rr, 0);
    check("postrst_dst_hs", last_x_hs, 2);
    check_stats("postrst");

    // randomized traffic with gaps, random backpressure and config churn
    gaps = 1'b1; rdy_mode = 1; rand_cfg = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push_msg($urandom_range(0, 6), $urandom);
      nw = 0;
      while (src_q.size() > 8 && nw < 500) begin @(posedge clk); nw++; end
    end
    @(posedge clk);
    #2;
    rand_cfg = 1'b0;
    cfg_dst_en = 4'b1111;
    wait_drain(8000, "random", nw);
    check_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_rx_lb_steer.md
Name: eth_rx_lb_steer

Overview:
Parametrised successor to the fixed RX-tile load balancer. It sits between the RX NoC-out formatter and the val/rdy-to-credit converter on the tile's processor port. It steers whole NoC messages (header flit plus body flits) to one of NUM_DST destination tiles, rewriting dst X/Y in the header flit. Destination selection is round-robin over an enable mask, or a flow hash; frames are never interleaved.

Parameters:
NOC_DATA_W, 512, NoC flit width
NUM_DST, 4, number of destination tiles; power of 2, 1..16
DST_IDX_W, $clog2(NUM_DST) (min 1), destination index width
XY_W, 8, X/Y coordinate width
LEN_W, 8, header message-length field width (body flit count)
DST_X_LSB / DST_Y_LSB, 0 / 8, bit positions of dst X/Y in header flit
LEN_LSB, 16, bit position of length field in header flit
FLOW_LSB, 64, bit position of flow-hash field in header flit
FLOW_W, 32, flow-hash field width
HASH_MODE, 0, 0 = round-robin, 1 = flow hash

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
src_lb_val  in  1  input flit valid
src_lb_data  in  NOC_DATA_W  input flit
lb_src_rdy  out  1  input ready
lb_dst_val  out  1  output flit valid
lb_dst_data  out  NOC_DATA_W  output flit, header rewritten
dst_lb_rdy  in  1  output ready
cfg_dst_x  in  NUM_DST*XY_W  per-destination X, entry i at [i*XY_W +: XY_W]
cfg_dst_y  in  NUM_DST*XY_W  per-destination Y
cfg_dst_en  in  NUM_DST  destination enable mask
lb_frame_cnt  out  NUM_DST*32  per-destination frame count; exists only with ETH_RX_LB_STATS_EN

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: lb_dst_val=0, lb_dst_data=0, FSM=IDLE, rr_ptr=0, body counter=0, lb_frame_cnt=0.
- Output stage: single register. lb_src_rdy = (state permits accept) & (!lb_dst_val | dst_lb_rdy). A flit is accepted on src_lb_val & lb_src_rdy and appears on lb_dst_data the next cycle.
- Throughput: sustains 1 flit/cycle while dst_lb_rdy=1.
- Output handshake: lb_dst_val/lb_dst_data hold stable until dst_lb_rdy.
- FSM IDLE:
  - Input flit is a header.
  - Round-robin mode: pick the first enabled index at or after rr_ptr, wrapping modulo NUM_DST.
  - Hash mode: idx = XOR-fold of the FLOW_W field to DST_IDX_W bits. If that entry is disabled, take the next enabled index (same wrap search).
  - If cfg_dst_en==0: lb_src_rdy=0 and stay in IDLE; no flit is dropped.
  - On accept:
    - Replace the dst X/Y fields with cfg values of idx; all other bits pass through.
    - Latch idx and len.
    - If len==0: stay IDLE (header-only message). Otherwise go to BODY with count=len.
    - Round-robin mode: rr_ptr <= idx+1 (wrapping).
- FSM BODY:
  - Flits pass unmodified.
  - Count decrements per accepted flit; on the accept with count==1, return to IDLE.
- Config changes: cfg_* sampled only at header accept. Changes mid-message do not affect the message in flight.
- Frame completion: a frame counts as complete on output-side acceptance of its last flit.
- Simultaneous events: output drain and input accept in the same cycle are legal; the register reloads.
- Reset mid-message: the partial message is discarded, FSM returns to IDLE, output invalid.

Optional Feature:
ETH_RX_LB_STATS_EN:
- Defined: 32-bit per-destination counters; counter idx increments when the last flit of a message bound to idx leaves the output (lb_dst_val & dst_lb_rdy). Counters wrap at 2^32 and reset to 0.
- Undefined: no counters, no lb_frame_cnt port, zero added state.

Decomposition:
- Shared package eth_rx_lb_pkg: lb_state_e enum (IDLE, BODY), HASH_MODE encodings, default header field offsets.
- One sub-module: eth_rx_lb_pick. Combinational next-enabled-index search given (start idx, en mask), reused by both modes.

Test Plan:
- RR, NUM_DST=4, en=4'b1111, four messages len=2, cfg_dst_x={3,2,1,0} -> header dst X 0,1,2,3 in order; 12 output flits; bodies byte-identical.
- RR, en=4'b1010 -> destinations 1,3,1,3; rr_ptr wraps from 3 to 1.
- Hash, flow fields 0x0000_0001 and 0x0001_0000 -> XOR-fold gives idx 1 for both. Disable idx 1 -> both redirect to idx 2.
- Backpressure: dst_lb_rdy toggled 1 cycle in 3 during a len=5 message -> no loss or duplication; data stable while stalled; lb_src_rdy low whenever output is full and not draining.
- cfg_dst_en=0 with a pending header -> lb_src_rdy stays 0 for 20 cycles. Set en=4'b0001 -> header accepted next cycle to dst 0.
- len=0 back-to-back headers, reset asserted mid-BODY of a len=4 message -> FSM IDLE, lb_dst_val=0; with ETH_RX_LB_STATS_EN, only completed messages counted.
